fsw_monitor: RTL and testbench

Receive-side checker for the complementary switching clock pair. It samples `fsw` and `fsw_bar` in the `clk` domain and measures the period and high time of `fsw`, plus the `fsw`→`fsw_bar` rising-edge phase offset. It compares each measurement against configured expectations and raises lock and error status. It sits downstream of the switching clock source, ahead of the gate-drive enable logic, which must not enable the power stage until `locked` is high.

---
 rtl/fsw_monitor.sv | 161 ++++++++++++++++
 tb/tb_fsw_monitor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fsw_monitor.sv
// Receive-side checker for the fsw/fsw_bar switching clock pair: measures period, high time and phase, and reports lock and sticky errors.
// Optional build macro FSW_MON_TOL_EN accepts +/-1 cycle on each measurement instead of an exact match.
module fsw_monitor #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned EXP_PERIOD = 10,
  parameter int unsigned EXP_HIGH   = 2,
  parameter int unsigned EXP_PHASE  = 5,
  parameter int unsigned LOCK_N     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fsw,
  input  logic             fsw_bar,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic [CNT_W-1:0] phase_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             overlap_err,
  output logic             fmt_err,
  output logic             stall_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int unsigned      GOOD_W  = $clog2(LOCK_N + 1);

  typedef enum logic {ST_WAIT, ST_MEAS} state_t;

  state_t            state_q, state_d;
  logic              fsw_d_q, fsw_bar_d_q;
  logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]  hi_cap_q, hi_cap_d;
  logic [CNT_W-1:0]  ph_cap_q, ph_cap_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic [CNT_W-1:0]  phase_q, phase_d;
  logic              valid_q, valid_d;
  logic              locked_q, locked_d;
  logic              overlap_q, overlap_d;
  logic              fmt_q, fmt_d;
  logic              stall_q, stall_d;

  logic rise, fall, bar_rise, stall, meas_good, fmt_set;

  function automatic logic in_range(input logic [CNT_W-1:0] v, input int unsigned e);
`ifdef FSW_MON_TOL_EN
    int d;
    d = int'(v) - int'(e);
    return (d >= -1) && (d <= 1);
`else
    return v == CNT_W'(e);
`endif
  endfunction

  always_comb begin
    rise     = fsw & ~fsw_d_q;
    fall     = ~fsw & fsw_d_q;
    bar_rise = fsw_bar & ~fsw_bar_d_q;

    per_cnt_d = rise ? CNT_W'(1) : ((per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + 1'b1);
    hi_cnt_d  = rise ? CNT_W'(1) : ((fsw && hi_cnt_q != CNT_MAX) ? hi_cnt_q + 1'b1 : hi_cnt_q);
    hi_cap_d  = fall ? hi_cnt_q : hi_cap_q;
    // Non-zero ph_cap marks that this period's first fsw_bar rise is already recorded.
    ph_cap_d  = rise ? '0 : ((bar_rise && ph_cap_q == '0) ? per_cnt_q : ph_cap_q);

    stall     = (per_cnt_q == CNT_MAX) && !rise;
    meas_good = in_range(per_cnt_q, EXP_PERIOD) && in_range(hi_cap_q, EXP_HIGH) &&
                in_range(ph_cap_q, EXP_PHASE) && (ph_cap_q != '0);

    state_d    = state_q;
    period_d   = period_q;
    high_d     = high_q;
    phase_d    = phase_q;
    valid_d    = 1'b0;
    good_cnt_d = good_cnt_q;
    fmt_set    = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (rise) state_d = ST_MEAS;
      end
      ST_MEAS: begin
        if (rise) begin
          period_d = per_cnt_q;
          high_d   = hi_cap_q;
          phase_d  = ph_cap_q;
          valid_d  = 1'b1;
          if (meas_good) begin
            if (good_cnt_q != GOOD_W'(LOCK_N)) good_cnt_d = good_cnt_q + 1'b1;
          end else begin
            fmt_set    = 1'b1;
            good_cnt_d = '0;
          end
        end
      end
      default: state_d = ST_WAIT;
    endcase

    if (stall) begin
      state_d    = ST_WAIT;
      good_cnt_d = '0;
    end

    // Lock tracks the saturated good-period count, so every clear of good_cnt also drops lock.
    locked_d  = (good_cnt_d == GOOD_W'(LOCK_N));
    overlap_d = (fsw & fsw_bar) | (overlap_q & ~err_clr);
    fmt_d     = fmt_set | (fmt_q & ~err_clr);
    stall_d   = stall | (stall_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_WAIT;
      fsw_d_q     <= 1'b0;
      fsw_bar_d_q <= 1'b0;
      per_cnt_q   <= '0;
      hi_cnt_q    <= '0;
      hi_cap_q    <= '0;
      ph_cap_q    <= '0;
      good_cnt_q  <= '0;
      period_q    <= '0;
      high_q      <= '0;
      phase_q     <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      overlap_q   <= 1'b0;
      fmt_q       <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fsw_d_q     <= fsw;
      fsw_bar_d_q <= fsw_bar;
      per_cnt_q   <= per_cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      hi_cap_q    <= hi_cap_d;
      ph_cap_q    <= ph_cap_d;
      good_cnt_q  <= good_cnt_d;
      period_q    <= period_d;
      high_q      <= high_d;
      phase_q     <= phase_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      overlap_q   <= overlap_d;
      fmt_q       <= fmt_d;
      stall_q     <= stall_d;
    end
  end

  assign period_out  = period_q;
  assign high_out    = high_q;
  assign phase_out   = phase_q;
  assign meas_valid  = valid_q;
  assign locked      = locked_q;
  assign overlap_err = overlap_q;
  assign fmt_err     = fmt_q;
  assign stall_err   = stall_q;

endmodule

// File: tb/tb_fsw_monitor.sv
// Self-checking bench for fsw_monitor: table of switching periods, scoreboard of expected measurements, hand sequences for overlap, stall and reset.
module tb_fsw_monitor;

  logic       clk = 1'b0;
  logic       reset, fsw, fsw_bar, err_clr;
  logic [7:0] period_out, high_out, phase_out;
  logic       meas_valid, locked, overlap_err, fmt_err, stall_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fsw_monitor #(
    .CNT_W(8), .EXP_PERIOD(10), .EXP_HIGH(2), .EXP_PHASE(5), .LOCK_N(4)
  ) dut (
    .clk(clk), .reset(reset), .fsw(fsw), .fsw_bar(fsw_bar), .err_clr(err_clr),
    .period_out(period_out), .high_out(high_out), .phase_out(phase_out),
    .meas_valid(meas_valid), .locked(locked), .overlap_err(overlap_err),
    .fmt_err(fmt_err), .stall_err(stall_err)
  );

  typedef struct {int per; int hi; int ph; bit lock; bit fmt;} vec_t;
  typedef struct {int due; int per; int hi; int ph; bit lock; bit fmt;} exp_t;

  exp_t sb[$];
  vec_t pend;
  bit   pend_valid = 1'b0;
  vec_t tbl[17];

  function automatic vec_t mk(input int per, input int hi, input int ph, input bit lk, input bit fm);
    vec_t v;
    v.per = per; v.hi = hi; v.ph = ph; v.lock = lk; v.fmt = fm;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"},  int'(period_out),  0);
    chk({tag, "_high"},    int'(high_out),    0);
    chk({tag, "_phase"},   int'(phase_out),   0);
    chk({tag, "_valid"},   int'(meas_valid),  0);
    chk({tag, "_locked"},  int'(locked),      0);
    chk({tag, "_overlap"}, int'(overlap_err), 0);
    chk({tag, "_fmt"},     int'(fmt_err),     0);
    chk({tag, "_stall"},   int'(stall_err),   0);
  endtask

  // The rise that starts a period completes the previous pending period.
  task automatic push_pending();
    exp_t e;
    if (pend_valid) begin
      e.due = cyc + 1; e.per = pend.per; e.hi = pend.hi; e.ph = pend.ph;
      e.lock = pend.lock; e.fmt = pend.fmt;
      sb.push_back(e);
    end
  endtask

  task automatic drive_period(input vec_t v, input bit meas, input int clr_at, input int rst_at);
    for (int i = 0; i < v.per; i++) begin
      step();
      if (i == 0) begin
        push_pending();
        pend_valid = meas;
        pend       = v;
      end
      if (clr_at >= 0 && i == clr_at + 1) begin
        chk("clr_overlap", int'(overlap_err), 0);
        chk("clr_fmt",     int'(fmt_err),     0);
        chk("clr_stall",   int'(stall_err),   0);
      end
      if (rst_at >= 0 && i == rst_at + 1) begin
        chk_all_zero("midrst");
        pend_valid = 1'b0;
      end
      fsw     = (i < v.hi);
      fsw_bar = (v.ph != 0) && (i >= v.ph) && (i < v.ph + 3);
      err_clr = (i == clr_at);
      reset   = (rst_at >= 0) && (i == rst_at);
    end
  endtask

  always @(negedge clk) begin
    if (meas_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_meas_valid at cycle %0d: got pulse expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("meas_time",   cyc,               e.due);
        chk("period_out",  int'(period_out),  e.per);
        chk("high_out",    int'(high_out),    e.hi);
        chk("phase_out",   int'(phase_out),   e.ph);
        chk("locked",      int'(locked),      int'(e.lock));
        chk("fmt_err",     int'(fmt_err),     int'(e.fmt));
      end
    end else if (sb.size() != 0 && cyc > sb[0].due) begin
      checks++; errors++;
      $display("FAIL missing_meas_valid at cycle %0d: got none expected pulse at cycle %0d", cyc, sb[0].due);
      void'(sb.pop_front());
    end
  end

  initial begin
    tbl[0]  = mk(10, 2, 5, 0, 0);
    tbl[1]  = mk(10, 2, 5, 0, 0);
    tbl[2]  = mk(10, 2, 5, 0, 0);
    tbl[3]  = mk(10, 2, 5, 1, 0);
    tbl[4]  = mk(10, 2, 5, 1, 0);
`ifdef FSW_MON_TOL_EN
    tbl[5]  = mk(10, 3, 5, 1, 0);
    tbl[6]  = mk(10, 2, 5, 1, 0);
    tbl[7]  = mk(10, 2, 5, 1, 0);
    tbl[8]  = mk(10, 2, 5, 1, 0);
    tbl[9]  = mk(10, 2, 5, 1, 0);
    tbl[10] = mk(10, 2, 0, 0, 1);
    tbl[11] = mk(10, 2, 5, 0, 1);
    tbl[12] = mk(11, 2, 5, 0, 1);
    tbl[13] = mk(10, 2, 5, 0, 1);
    tbl[14] = mk(10, 2, 5, 1, 1);
    tbl[15] = mk(10, 2, 5, 1, 1);
    tbl[16] = mk(10, 2, 5, 1, 1);
`else
    tbl[5]  = mk(10, 3, 5, 0, 1);
    tbl[6]  = mk(10, 2, 5, 0, 1);
    tbl[7]  = mk(10, 2, 5, 0, 1);
    tbl[8]  = mk(10, 2, 5, 0, 1);
    tbl[9]  = mk(10, 2, 5, 1, 1);
    tbl[10] = mk(10, 2, 0, 0, 1);
    tbl[11] = mk(10, 2, 5, 0, 1);
    tbl[12] = mk(11, 2, 5, 0, 1);
    tbl[13] = mk(10, 2, 5, 0, 1);
    tbl[14] = mk(10, 2, 5, 0, 1);
    tbl[15] = mk(10, 2, 5, 0, 1);
    tbl[16] = mk(10, 2, 5, 1, 1);
`endif

    reset = 1'b1; fsw = 1'b0; fsw_bar = 1'b0; err_clr = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    reset = 1'b0;

    // Overlap handling from the WAIT state, including clear-versus-set priority.
    step(); chk("ovl_idle", int'(overlap_err), 0); fsw = 1'b1; fsw_bar = 1'b1;
    step(); chk("ovl_set",  int'(overlap_err), 1); fsw_bar = 1'b0; err_clr = 1'b1;
    step(); chk("ovl_clr",  int'(overlap_err), 0); fsw_bar = 1'b1; err_clr = 1'b1;
    step(); chk("ovl_clr_vs_set", int'(overlap_err), 1); fsw = 1'b0; fsw_bar = 1'b0; err_clr = 1'b0;
    step(); chk("ovl_sticky", int'(overlap_err), 1);
    reset = 1'b1;
    step(); chk("ovl_reset", int'(overlap_err), 0);
    reset = 1'b0;

    for (int k = 0; k < 17; k++) drive_period(tbl[k], 1'b1, -1, -1);

    // Stall: one rise, then fsw held low until per_cnt saturates.
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 0) begin
        push_pending();
        pend_valid = 1'b0;
      end
      if (i == 255) begin
        chk("stall_before_sat", int'(stall_err), 0);
        chk("locked_pre_stall", int'(locked),    1);
      end
      if (i == 256) begin
        chk("stall_set",    int'(stall_err), 1);
        chk("stall_unlock", int'(locked),    0);
      end
      fsw = (i < 2); fsw_bar = 1'b0; err_clr = 1'b0;
    end

    drive_period(mk(10, 2, 5, 0, 0), 1'b1, 3, -1);
    drive_period(mk(10, 2, 5, 0, 0), 1'b1, -1, -1);
    drive_period(mk(10, 2, 5, 0, 0), 1'b1, -1, -1);
    drive_period(mk(10, 2, 5, 1, 0), 1'b1, -1, -1);
    drive_period(mk(10, 2, 5, 1, 0), 1'b1, -1, -1);

    drive_period(mk(10, 2, 5, 0, 0), 1'b0, -1, 3);
    drive_period(mk(10, 2, 5, 0, 0), 1'b1, -1, -1);
    drive_period(mk(10, 2, 5, 0, 0), 1'b1, -1, -1);
    drive_period(mk(10, 2, 5, 0, 0), 1'b0, -1, -1);

    repeat (3) step();
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
